// File: rtl/count_timer_pkg.sv
// rtl/count_timer_pkg.sv - shared constants and types for the count timer controller
package count_timer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int PRE_W_DEF = 8;

    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_ONESHOT  = 2'b10;
    localparam logic [1:0] OP_PERIODIC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Both start opcodes share the top bit.
    function automatic logic is_start(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock into counter ticks
module tick_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale_q,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // A tick fires on the cycle the divider reaches its terminal value.
    assign tick = enable && (pre_cnt == prescale_q);

    // Divider counts 0..prescale_q, wraps on tick, holds while disabled.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_timer_ctrl.sv
// rtl/count_timer_ctrl.sv - command-driven one-shot/periodic timer controller
module count_timer_ctrl
    import count_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic             irq,
    input  logic             irq_ack,
    output logic             ovr
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] prescale_q;
    logic             periodic;
    logic             accept;
    logic             start_acc;
    logic             tick;
    logic             match;

    // Ready is decoded straight from state so the host sees it without a cycle of lag.
    assign cmd_ready = (state != ARM);
    assign accept    = cmd_valid && cmd_ready;
    assign start_acc = accept && is_start(cmd_op);
    assign match     = (state == RUN) && tick && (count == limit);

    tick_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clock      (clock),
        .reset      (reset),
        .clear      ((state == ARM) || start_acc),
        .enable     (state == RUN),
        .prescale_q (prescale_q),
        .tick       (tick)
    );

    // Next state and count; an accepted command overrides the timer's own progress.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ARM: begin
                state_nxt = RUN;
                count_nxt = '0;
            end
            RUN: begin
                if (tick) begin
                    if (count == limit) begin
                        if (periodic) begin
                            count_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (accept) begin
            if (cmd_op == OP_STOP) begin
                state_nxt = IDLE;
                count_nxt = count;
            end else if (is_start(cmd_op)) begin
                state_nxt = ARM;
                count_nxt = '0;
            end
        end
    end

    // State, counter, configuration and status registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            limit      <= '1;
            prescale_q <= '0;
            periodic   <= 1'b0;
            busy       <= 1'b0;
            expire     <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            busy   <= (state_nxt != IDLE);
            expire <= match;
            if (accept && (cmd_op == OP_LOAD)) begin
                limit <= cmd_data;
            end
            if (start_acc) begin
                periodic   <= (cmd_op == OP_PERIODIC);
                prescale_q <= prescale;
            end
        end
    end

    // Sticky interrupt; a new expire wins over a simultaneous ack for irq.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (match) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
            if (irq_ack) begin
                ovr <= 1'b0;
            end else if (match && irq) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_timer_ctrl.sv
// tb/tb_count_timer_ctrl.sv - self-checking bench for count_timer_ctrl
module tb_count_timer_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_ARM  = 1;
    localparam int S_RUN  = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [7:0]  prescale;
    logic [31:0] count;
    logic        busy;
    logic        expire;
    logic        irq;
    logic        irq_ack;
    logic        ovr;

    int n_vec = 0;
    int n_err = 0;

    int          m_st;
    logic [31:0] m_count;
    logic [31:0] m_limit;
    int          m_ps;
    bit          m_per;
    int          m_k;
    bit          m_exp;
    bit          m_irq;
    bit          m_ovr;

    always #5 clock = ~clock;

    count_timer_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .prescale  (prescale),
        .count     (count),
        .busy      (busy),
        .expire    (expire),
        .irq       (irq),
        .irq_ack   (irq_ack),
        .ovr       (ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a tick lands on every (ps+1)-th cycle spent in RUN since the last arm.
    task automatic model_edge(input bit v, input logic [1:0] op, input logic [31:0] d,
                              input logic [7:0] ps, input bit ack, input bit rst);
        bit          acc;
        bit          tick;
        bit          hit;
        int          n_st;
        logic [31:0] n_cnt;
        if (rst) begin
            m_st = S_IDLE; m_count = 0; m_limit = 32'hFFFF_FFFF; m_ps = 0;
            m_per = 0; m_k = 0; m_exp = 0; m_irq = 0; m_ovr = 0;
            return;
        end
        acc   = v && (m_st != S_ARM);
        tick  = (m_st == S_RUN) && ((m_k % (m_ps + 1)) == m_ps);
        hit   = tick && (m_count == m_limit);
        n_st  = m_st;
        n_cnt = m_count;
        if (m_st == S_ARM) begin
            n_st = S_RUN; n_cnt = 0; m_k = 0;
        end else if (m_st == S_RUN) begin
            m_k++;
            if (tick) begin
                if (!hit) n_cnt = m_count + 1;
                else if (m_per) n_cnt = 0;
                else n_st = S_IDLE;
            end
        end
        if (acc) begin
            if (op == 2'b00) begin
                n_st = S_IDLE; n_cnt = m_count;
            end else if (op == 2'b01) begin
                m_limit = d;
            end else begin
                n_st = S_ARM; n_cnt = 0; m_per = (op == 2'b11); m_ps = int'(ps); m_k = 0;
            end
        end
        if (hit && m_irq && !ack) m_ovr = 1;
        else if (ack) m_ovr = 0;
        if (hit) m_irq = 1;
        else if (ack) m_irq = 0;
        m_exp   = hit;
        m_st    = n_st;
        m_count = n_cnt;
    endtask

    task automatic check_all();
        chk("count", count, m_count);
        chk("busy", busy, m_st != S_IDLE);
        chk("expire", expire, m_exp);
        chk("irq", irq, m_irq);
        chk("ovr", ovr, m_ovr);
        chk("cmd_ready", cmd_ready, m_st != S_ARM);
    endtask

    task automatic cycle(input bit v, input logic [1:0] op, input logic [31:0] d,
                         input logic [7:0] ps, input bit ack, input bit rst);
        reset = rst; cmd_valid = v; cmd_op = op; cmd_data = d; prescale = ps; irq_ack = ack;
        @(posedge clock);
        model_edge(v, op, d, ps, ack, rst);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] d, input logic [7:0] ps);
        cycle(1, op, d, ps, 0, 0);
    endtask

    task automatic run_until_count(input logic [31:0] target, input int budget);
        int n = 0;
        while (m_count != target && n < budget) begin
            idle();
            n++;
        end
        chk("reach_count", count, target);
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; prescale = 0; irq_ack = 0;
        cycle(0, 2'b00, 0, 0, 0, 1);
        chk("reset_count", count, 0);
        chk("reset_ready", cmd_ready, 1);

        // Reset mid-RUN at count 0x1234.
        cmd(2'b10, 0, 0);
        run_until_count(32'h1234, 6000);
        cycle(0, 2'b00, 0, 0, 0, 1);
        chk("midrun_reset_count", count, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_ready", cmd_ready, 1);

        // One-shot, limit 3, prescale 0.
        cmd(2'b01, 3, 0);
        cmd(2'b10, 0, 0);
        chk("arm_ready", cmd_ready, 0);
        chk("arm_busy", busy, 1);
        repeat (2) idle();
        chk("os_count_e2", count, 1);
        repeat (2) idle();
        chk("os_count_e4", count, 3);
        idle();
        chk("os_expire_e5", expire, 1);
        chk("os_count_e5", count, 3);
        chk("os_idle_e5", busy, 0);
        chk("os_irq_e5", irq, 1);
        idle();
        chk("os_expire_e6", expire, 0);
        chk("os_count_e6", count, 3);

        // Periodic, limit 1, prescale 2.
        cycle(0, 2'b00, 0, 0, 1, 0);
        cmd(2'b01, 1, 0);
        cmd(2'b11, 0, 2);
        repeat (20) idle();
        cmd(2'b00, 0, 0);
        chk("stop_busy", busy, 0);

        // Periodic limit 0: overrun, ack, ack coincident with expire.
        cycle(0, 2'b00, 0, 0, 1, 0);
        cmd(2'b01, 0, 0);
        cmd(2'b11, 0, 0);
        idle();
        idle();
        chk("p0_first_irq", irq, 1);
        chk("p0_first_ovr", ovr, 0);
        idle();
        chk("p0_second_ovr", ovr, 1);
        cmd(2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0, 1, 0);
        chk("ack_irq", irq, 0);
        chk("ack_ovr", ovr, 0);
        cmd(2'b11, 0, 0);
        idle();
        idle();
        cycle(0, 2'b00, 0, 0, 1, 0);
        chk("ack_coinc_irq", irq, 1);
        chk("ack_coinc_ovr", ovr, 0);
        cmd(2'b00, 0, 0);

        // cmd_valid held through ARM; restart in RUN at count 5.
        cmd(2'b01, 100, 0);
        cmd(2'b10, 0, 0);
        cmd(2'b01, 50, 0);
        chk("arm_blocked_ready", cmd_ready, 1);
        run_until_count(5, 20);
        cmd(2'b10, 0, 0);
        idle();
        chk("restart_count", count, 0);
        idle();
        chk("restart_count_inc", count, 1);

        // STOP coincident with a periodic match.
        cmd(2'b01, 4, 0);
        cmd(2'b11, 0, 0);
        run_until_count(4, 20);
        cmd(2'b00, 0, 0);
        chk("stop_match_expire", expire, 1);
        chk("stop_match_count", count, 4);
        chk("stop_match_busy", busy, 0);

        // Lowering the limit below count keeps counting upward.
        cmd(2'b01, 100, 0);
        cmd(2'b11, 0, 0);
        run_until_count(7, 20);
        cmd(2'b01, 2, 0);
        idle();
        idle();
        chk("lowered_limit_count", count, 10);
        chk("lowered_limit_no_expire", expire, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 4) == 0, 2'($urandom % 4), $urandom % 6, 8'($urandom % 3),
                  ($urandom % 8) == 0, ($urandom % 64) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_timer_ctrl.md
# count_timer_ctrl

Command-driven controller that sequences a 32-bit up-counter as a programmable timer, supporting one-shot and periodic modes, a prescaled tick, and a sticky interrupt with overrun detection. It sits beside the counter datapath: it owns the counter's clear, enable and compare logic, and exposes a valid/ready command port to the host-side register block.

## Interface
- WIDTH, 32, counter and limit width
- PRE_W, 8, prescaler width
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts command this cycle
- cmd_op  in  2  00 STOP, 01 LOAD_LIMIT, 10 START_ONESHOT, 11 START_PERIODIC
- cmd_data  in  WIDTH  limit value for LOAD_LIMIT; ignored otherwise
- prescale  in  PRE_W  tick divider, sampled when START is accepted
- count  out  WIDTH  current counter value
- busy  out  1  state is ARM or RUN
- expire  out  1  one-cycle pulse on terminal count
- irq  out  1  sticky, set by expire
- irq_ack  in  1  clears irq and ovr
- ovr  out  1  sticky, expire occurred while irq already set

## Operation
- States: IDLE, ARM, RUN. Reset: IDLE, count=0, limit=all ones, prescale_q=0, mode=oneshot, expire=0, irq=0, ovr=0, busy=0.
- cmd_ready = 1 in IDLE and RUN, 0 in ARM. A command is accepted on an edge with cmd_valid & cmd_ready.
- LOAD_LIMIT: limit <= cmd_data in any state; no state change. In RUN, the new limit is used from the next cycle's compare.
- START_*: latch mode and prescale_q <= prescale, go to ARM; ARM clears count and prescaler; ARM -> RUN unconditionally. START while in RUN restarts (count cleared in ARM).
- STOP: -> IDLE from any state; count holds its value.
- tick: in RUN, asserted when the prescaler equals prescale_q; the prescaler then wraps to 0, otherwise it increments. prescale_q=0 gives a tick every RUN cycle.
- On a tick with count != limit: count <= count+1. On a tick with count == limit: expire <= 1 and
  - oneshot: -> IDLE, count holds limit
  - periodic: count <= 0, stay in RUN
- Period = (limit+1)*(prescale_q+1) cycles. limit=0: oneshot expires on the first tick; periodic expires on every tick.
- count is never compared above limit. If limit is lowered below count in RUN, count increments until it wraps through 2^WIDTH-1 -> 0, then matches.
- irq: set on expire. irq_ack clears irq and ovr. ack and expire in the same cycle leave irq=1 and ovr=0. expire while irq=1 and no ack sets ovr.
- Command accepted in the same cycle as a match: the command decides the next state and count; expire still pulses.
- reset at any time, including mid-RUN: all registers return to their reset values on the next edge.

## Timing
- START accepted at edge E0 -> ARM after E0 (count=0, busy=1, cmd_ready=0) -> RUN after E1 -> with prescale 0, count=1 after E2.
- expire is registered: it is high for exactly the cycle after the edge that took the match. irq rises in the same cycle as expire.
- Example, oneshot, limit=3, prescale 0:
  - count 1, 2, 3 after E2, E3, E4
  - after E5: IDLE, expire=1, count=3
  - after E6: expire=0
- STOP accepted at edge E: IDLE and busy=0 after E.
- Outputs are registered, except cmd_ready, which is decoded from the state register only.

## Structure
- Package count_timer_pkg: op encodings (OP_STOP, OP_LOAD, OP_ONESHOT, OP_PERIODIC), state enum (IDLE/ARM/RUN), default WIDTH/PRE_W.
- One sub-module, tick_prescaler (clear, enable, prescale_q -> tick).
- FSM, counter, compare and irq/ovr logic live in the top module.

## Test plan
- Reset mid-RUN with count=0x1234 -> next cycle: IDLE, count=0, limit=0xFFFFFFFF, irq=0, ovr=0, cmd_ready=1.
- LOAD_LIMIT 3, START_ONESHOT, prescale 0 -> count 1,2,3; expire one cycle at E5; IDLE; count stays 3; irq=1.
- LOAD_LIMIT 1, START_PERIODIC, prescale 2 -> expire every 6 cycles; count sequence 0,1,0,1,… with each value held 3 cycles.
- Periodic limit 0, no irq_ack -> second expire sets ovr=1; irq_ack -> irq=0, ovr=0; ack coincident with expire -> irq=1, ovr=0.
- cmd_valid held during ARM -> cmd_ready=0 for exactly one cycle; START in RUN at count=5 -> count=0 after the ARM cycle.
- STOP coincident with match in periodic -> IDLE, expire=1, count=limit; LOAD_LIMIT 2 at count=7 in RUN -> wraps via 0xFFFFFFFF -> 0, expires at 2.
